sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 20, SRAM address width; DATA_W, 16, SRAM data width; WAIT_CYCLES, 2, cycles the SRAM strobes stay active per access (legal range 1..15).
REQ-002 Clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 p0_req, p1_req  in  1  access request; the requester holds it high until it sees its ack.
REQ-005 p0_we, p1_we  in  1  1 = write, 0 = read; valid while the matching req is high.
REQ-006 p0_addr, p1_addr  in  ADDR_W  word address.
REQ-007 p0_wdata, p1_wdata  in  DATA_W  write data.
REQ-008 p0_ack, p1_ack  out  1  single-cycle pulse marking access completion.
REQ-009 rdata  out  DATA_W  last read word; shared by both ports.
REQ-010 grant  out  2  one-hot owner of the current access (bit0 = p0); 00 when idle.
REQ-011 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.
REQ-012 ADDR  out  ADDR_W  SRAM address.
REQ-013 Data_to_SRAM  out  DATA_W  write data sent to the tristate buffer.
REQ-014 Data_from_SRAM  in  DATA_W  read data returned from the tristate buffer.
REQ-015 tristate_output_enable  out  1  high only while the block drives write data.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-017 In IDLE, all strobes SHALL be 1, grant SHALL be 00, tristate_output_enable SHALL be 0, and both acks SHALL be 0.
REQ-018 In IDLE with any req high, the block SHALL select a winner, latch that port's addr/we/wdata, set grant, load a wait counter with WAIT_CYCLES-1, and go to ACCESS on the next edge.
REQ-019 Arbitration SHALL follow these rules:
- only one req high: that port wins;
- both high: the port not served last wins (round robin);
- a last_served pointer updates on every grant.
REQ-020 ACCESS SHALL last exactly WAIT_CYCLES cycles:
- Mem_CE=Mem_UB=Mem_LB=0 throughout;
- read: Mem_OE=0 and Mem_WE=1;
- write: Mem_WE=0, Mem_OE=1 and tristate_output_enable=1.
REQ-021 On the last ACCESS cycle, a read SHALL register Data_from_SRAM into rdata; a write SHALL leave rdata unchanged.
REQ-022 DONE SHALL last one cycle:
- all strobes 1 (bus turnaround / write recovery);
- the granted port's ack = 1;
- grant still shows the owner;
- next state is IDLE.
REQ-023 ADDR and Data_to_SRAM SHALL hold the latched values from the first ACCESS cycle through DONE, and SHALL keep their last values while IDLE.
REQ-024 Latency SHALL be fixed: if req is sampled in IDLE at cycle t, ack is high at cycle t+WAIT_CYCLES+1, with no back-pressure.
REQ-025 A req that drops during ACCESS SHALL NOT abort the access; the access completes and the ack is still issued.
REQ-026 Req inputs SHALL be ignored in ACCESS and DONE; a req still high after its ack is re-arbitrated in the next IDLE cycle.
REQ-027 Steady back-to-back throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-028 p0_ack and p1_ack SHALL never be high in the same cycle, and grant SHALL never be 11.

Reset
REQ-029 Reset SHALL force the following on the next edge:
- state IDLE;
- strobes all 1, grant 00, both acks 0, tristate_output_enable 0;
- rdata, ADDR and Data_to_SRAM all 0;
- last_served = p1, so p0 wins the first tie.
REQ-030 A Reset during ACCESS or DONE SHALL abandon the access with no ack, and the strobes SHALL be deasserted on that edge.

Verification
REQ-031 Single read, WAIT_CYCLES=2:
- stimulus: p0 read at addr 0x00012, Data_from_SRAM=0xBEEF;
- response: Mem_OE=0 for 2 cycles, p0_ack on the 3rd cycle after the request, rdata=0xBEEF, Mem_WE stays 1.
REQ-032 Single write:
- stimulus: p1 writes 0x1234 to 0x0FFFF;
- response: Mem_WE=0 and tristate_output_enable=1 for 2 cycles, ADDR=0x0FFFF, Data_to_SRAM=0x1234, p1_ack pulses once, rdata unchanged.
REQ-033 Contention after reset:
- stimulus: both reqs high continuously;
- response: grants alternate p0, p1, p0, p1; acks 4 cycles apart.
REQ-034 Dropped request:
- stimulus: p0 read starts, then p0_req drops in the first ACCESS cycle;
- response: the access completes and p0_ack still pulses.
REQ-035 Reset mid-write:
- stimulus: Reset asserted in the 2nd ACCESS cycle;
- response: next cycle Mem_WE=1, grant=00, no ack; a subsequent p1-only request is served normally.
REQ-036 WAIT_CYCLES=1 build:
- stimulus: one read;
- response: ack at request cycle + 2; every ack is a single-cycle pulse.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of an asynchronous SRAM.
// Each granted access runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (1 cycle),
// so latency and throughput are fixed and neither requester sees back-pressure.
// All outputs are registered.
//
// Ports:
//   Clk, Reset                 sole clock, synchronous active-high reset
//   pN_req/we/addr/wdata       per-port request (req held until ack)
//   pN_ack                     single-cycle completion pulse
//   rdata                      last word read (shared)
//   grant                      one-hot owner of the current access, 00 when idle
//   Mem_CE/UB/LB/OE/WE         active-low SRAM strobes
//   ADDR, Data_to_SRAM         latched address / write data for the SRAM
//   Data_from_SRAM             read data from the tristate buffer
//   tristate_output_enable     high while write data is driven onto the bus
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_ack,
    output logic              p1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              tristate_output_enable
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // The counter is loaded with WAIT_CYCLES-1 and the access ends when it reads 0.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_r;
    logic [3:0]        wait_cnt_r;
    logic              last_served_r;   // 0 = p0 served last, 1 = p1
    logic              we_r;

    logic              any_req_s;
    logic              win_s;           // 0 = p0 wins, 1 = p1 wins
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        any_req_s = p0_req | p1_req;
        if (p0_req && p1_req) begin
            win_s = ~last_served_r;
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            win_we_s    = p1_we;
            win_addr_s  = p1_addr;
            win_wdata_s = p1_wdata;
        end else begin
            win_we_s    = p0_we;
            win_addr_s  = p0_addr;
            win_wdata_s = p0_wdata;
        end
    end

    // Access sequencer: state, counter, latched request and all registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r                <= IDLE;
            wait_cnt_r             <= 4'd0;
            last_served_r          <= 1'b1;
            we_r                   <= 1'b0;
            p0_ack                 <= 1'b0;
            p1_ack                 <= 1'b0;
            grant                  <= 2'b00;
            rdata                  <= '0;
            ADDR                   <= '0;
            Data_to_SRAM           <= '0;
            Mem_CE                 <= 1'b1;
            Mem_UB                 <= 1'b1;
            Mem_LB                 <= 1'b1;
            Mem_OE                 <= 1'b1;
            Mem_WE                 <= 1'b1;
            tristate_output_enable <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    if (any_req_s) begin
                        state_r                <= ACCESS;
                        wait_cnt_r             <= WAIT_LOAD;
                        last_served_r          <= win_s;
                        we_r                   <= win_we_s;
                        grant                  <= win_s ? 2'b10 : 2'b01;
                        ADDR                   <= win_addr_s;
                        Data_to_SRAM           <= win_wdata_s;
                        Mem_CE                 <= 1'b0;
                        Mem_UB                 <= 1'b0;
                        Mem_LB                 <= 1'b0;
                        Mem_OE                 <= win_we_s;
                        Mem_WE                 <= ~win_we_s;
                        tristate_output_enable <= win_we_s;
                    end else begin
                        grant <= 2'b00;
                    end
                end
                ACCESS: begin
                    if (wait_cnt_r == 4'd0) begin
                        // Last strobe cycle: capture read data, release the bus.
                        if (!we_r) begin
                            rdata <= Data_from_SRAM;
                        end else begin
                            rdata <= rdata;
                        end
                        state_r                <= DONE;
                        p0_ack                 <= grant[0];
                        p1_ack                 <= grant[1];
                        Mem_CE                 <= 1'b1;
                        Mem_UB                 <= 1'b1;
                        Mem_LB                 <= 1'b1;
                        Mem_OE                 <= 1'b1;
                        Mem_WE                 <= 1'b1;
                        tristate_output_enable <= 1'b0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    grant   <= 2'b00;
                end
                default: begin
                    state_r                <= IDLE;
                    p0_ack                 <= 1'b0;
                    p1_ack                 <= 1'b0;
                    grant                  <= 2'b00;
                    Mem_CE                 <= 1'b1;
                    Mem_UB                 <= 1'b1;
                    Mem_LB                 <= 1'b1;
                    Mem_OE                 <= 1'b1;
                    Mem_WE                 <= 1'b1;
                    tristate_output_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
